ha_array_accum: RTL and testbench

HA_ARRAY_ACCUM -- requirements
Module: ha_array_accum

---
 rtl/mul8_ha_pkg.sv | 19 +
 rtl/ha_group_value.sv | 15 +
 rtl/ha_array_accum.sv | 118 +++++++++++
 tb/tb_ha_array_accum.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mul8_ha_pkg.sv
// Shared widths and FSM encoding for the half-adder array accumulator.
// Group vectors: 9-bit top row, 7-bit bottom row, 10-bit group value.
// Accumulator is 17 bits so the full unsaturated sum plus carry fits.
package mul8_ha_pkg;

  localparam int NUM_GROUPS = 4;
  localparam int T_W        = 9;
  localparam int B_W        = 7;
  localparam int G_W        = 10;
  localparam int ACC_W      = 17;
  localparam int CNT_W      = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ha_group_value.sv
// Exact value of one half-adder group: top row plus bottom row shifted by two.
// Purely combinational; result is 10 bits and cannot overflow.
// No state, no handshake.
module ha_group_value
  import mul8_ha_pkg::*;
(
  input  logic [T_W-1:0] t,
  input  logic [B_W-1:0] b,
  output logic [G_W-1:0] g
);

  // Bottom row carries weight 4 relative to the top row of the same group.
  assign g = {1'b0, t} + {1'b0, b, 2'b00};

endmodule

// File: rtl/ha_array_accum.sv
// Serial accumulator: one group value per cycle, weighted by 4^k, into 17 bits.
// Latency: accept at edge N -> out_valid after edge N+4; one product per >= 5 cycles.
// Optional macro HA_ACC_BIAS_EN preloads BIAS into the accumulator at accept.
module ha_array_accum
  import mul8_ha_pkg::*;
#(
  parameter logic [15:0] BIAS = 16'd0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [T_W-1:0] ha_array_0_t,
  input  logic [T_W-1:0] ha_array_1_t,
  input  logic [T_W-1:0] ha_array_2_t,
  input  logic [T_W-1:0] ha_array_3_t,
  input  logic [B_W-1:0] ha_array_0_b,
  input  logic [B_W-1:0] ha_array_1_b,
  input  logic [B_W-1:0] ha_array_2_b,
  input  logic [B_W-1:0] ha_array_3_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [15:0]    product,
  output logic           ovf
);

  state_t                            state;
  logic [CNT_W-1:0]                  cnt;
  logic [ACC_W-1:0]                  acc;
  logic [NUM_GROUPS-1:0][T_W-1:0]    t_q;
  logic [NUM_GROUPS-1:0][B_W-1:0]    b_q;

  logic [T_W-1:0]                    t_sel;
  logic [B_W-1:0]                    b_sel;
  logic [G_W-1:0]                    g;
  logic [ACC_W-1:0]                  addend;
  logic [ACC_W-1:0]                  acc_next;
  logic [ACC_W-1:0]                  acc_init;

`ifdef HA_ACC_BIAS_EN
  assign acc_init = {1'b0, BIAS};
`else
  // BIAS has no effect in this build; reduce it into a deliberately unused net.
  logic unused_bias;
  assign unused_bias = ^BIAS;
  assign acc_init    = '0;
`endif

  // Select the captured operands of the group currently being accumulated.
  always_comb begin
    t_sel = t_q[cnt];
    b_sel = b_q[cnt];
  end

  ha_group_value u_group (
    .t (t_sel),
    .b (b_sel),
    .g (g)
  );

  // Weight group k by 2^(2k) and add it to the running sum.
  always_comb begin
    addend   = {{(ACC_W-G_W){1'b0}}, g} << {cnt, 1'b0};
    acc_next = acc + addend;
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      t_q       <= '0;
      b_q       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      product   <= '0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            t_q      <= {ha_array_3_t, ha_array_2_t, ha_array_1_t, ha_array_0_t};
            b_q      <= {ha_array_3_b, ha_array_2_b, ha_array_1_b, ha_array_0_b};
            acc      <= acc_init;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= ACC;
          end
        end
        ACC: begin
          acc <= acc_next;
          cnt <= cnt + 2'd1;
          if (cnt == CNT_W'(NUM_GROUPS - 1)) begin
            product   <= acc_next[15:0];
            ovf       <= acc_next[16];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // Result holds until the consumer takes it; no bypass into a new accept.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ha_array_accum.sv
// Directed, table-driven bench for ha_array_accum.
// Checks reset state, latency, products, overflow, hold-under-backpressure,
// operand capture and mid-accumulation reset.
module tb_ha_array_accum;

  localparam logic [15:0] TB_BIAS = 16'd5;
`ifdef HA_ACC_BIAS_EN
  localparam logic [16:0] BIAS_ADD = {1'b0, TB_BIAS};
`else
  localparam logic [16:0] BIAS_ADD = 17'd0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  ha_array_0_t, ha_array_1_t, ha_array_2_t, ha_array_3_t;
  logic [6:0]  ha_array_0_b, ha_array_1_b, ha_array_2_b, ha_array_3_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        ovf;

  int passed = 0;
  int total  = 0;

  ha_array_accum #(.BIAS(TB_BIAS)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ha_array_0_t (ha_array_0_t),
    .ha_array_1_t (ha_array_1_t),
    .ha_array_2_t (ha_array_2_t),
    .ha_array_3_t (ha_array_3_t),
    .ha_array_0_b (ha_array_0_b),
    .ha_array_1_b (ha_array_1_b),
    .ha_array_2_b (ha_array_2_b),
    .ha_array_3_b (ha_array_3_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .ovf          (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][8:0] t;
    logic [3:0][6:0] b;
    logic [16:0]     sum;
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mk(input logic [8:0] t3, t2, t1, t0,
                              input logic [6:0] b3, b2, b1, b0,
                              input logic [16:0] sum);
    vec_t v;
    v.t   = {t3, t2, t1, t0};
    v.b   = {b3, b2, b1, b0};
    v.sum = sum;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic apply(input logic [3:0][8:0] t, input logic [3:0][6:0] b);
    ha_array_0_t = t[0]; ha_array_1_t = t[1]; ha_array_2_t = t[2]; ha_array_3_t = t[3];
    ha_array_0_b = b[0]; ha_array_1_b = b[1]; ha_array_2_b = b[2]; ha_array_3_b = b[3];
  endtask

  // Waits (bounded) for in_ready, drives operands and takes one accept edge.
  task automatic accept(input string name, input logic [3:0][8:0] t, input logic [3:0][6:0] b);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) check({name, " in_ready timeout"}, 32'(in_ready), 32'd1);
    apply(t, b);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts edges from the accept edge until out_valid rises (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [16:0] exp17;
    logic [3:0][8:0] t_ones, t_zero, t_a;
    logic [3:0][6:0] b_ones, b_zero, b_a;

    t_ones = {4{9'h1FF}}; b_ones = {4{7'h7F}};
    t_zero = '0;          b_zero = '0;

    vecs[0] = mk(9'h000, 9'h000, 9'h000, 9'h000, 7'h00, 7'h00, 7'h00, 7'h00, 17'd0);
    vecs[1] = mk(9'h000, 9'h000, 9'h000, 9'h001, 7'h00, 7'h00, 7'h00, 7'h00, 17'd1);
    vecs[2] = mk(9'h000, 9'h000, 9'h000, 9'h000, 7'h00, 7'h00, 7'h40, 7'h00, 17'd1024);
    vecs[3] = mk(9'h100, 9'h000, 9'h000, 9'h000, 7'h00, 7'h00, 7'h00, 7'h00, 17'd16384);
    vecs[4] = mk(9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 17'd86615);
    vecs[5] = mk(9'h000, 9'h000, 9'h000, 9'h1FF, 7'h00, 7'h00, 7'h00, 7'h00, 17'd511);
    vecs[6] = mk(9'h000, 9'h000, 9'h000, 9'h000, 7'h00, 7'h00, 7'h00, 7'h7F, 17'd508);
    vecs[7] = mk(9'h000, 9'h0AA, 9'h000, 9'h000, 7'h01, 7'h00, 7'h00, 7'h00, 17'd2976);
    vecs[8] = mk(9'h000, 9'h000, 9'h005, 9'h003, 7'h00, 7'h01, 7'h00, 7'h01, 17'd91);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    apply(t_zero, b_zero);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset product", 32'(product), 32'd0);
    check("reset ovf", 32'(ovf), 32'd0);

    // Table-driven transactions.
    for (int i = 0; i < 9; i++) begin
      exp17 = vecs[i].sum + BIAS_ADD;
      accept($sformatf("vec%0d", i), vecs[i].t, vecs[i].b);
      check($sformatf("vec%0d in_ready busy", i), 32'(in_ready), 32'd0);
      wait_done(lat);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'd4);
      check($sformatf("vec%0d product", i), 32'(product), 32'(exp17[15:0]));
      check($sformatf("vec%0d ovf", i), 32'(ovf), 32'(exp17[16]));
      release_out();
      check($sformatf("vec%0d back to idle", i), 32'({out_valid, in_ready}), 32'd1);
    end

    // All ones held under backpressure; inputs change during DONE.
    exp17 = 17'd86615 + BIAS_ADD;
    accept("hold", t_ones, b_ones);
    wait_done(lat);
    check("hold latency", 32'(lat), 32'd4);
    apply(t_zero, b_zero);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("hold%0d product", k), 32'(product), 32'(exp17[15:0]));
      check($sformatf("hold%0d ovf", k), 32'(ovf), 32'(exp17[16]));
      check($sformatf("hold%0d out_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("hold%0d in_ready", k), 32'(in_ready), 32'd0);
    end
    release_out();

    // Operands change right after accept; captured values must be used.
    t_a = {9'h000, 9'h000, 9'h000, 9'h003};
    b_a = '0;
    exp17 = 17'd3 + BIAS_ADD;
    accept("capture", t_a, b_a);
    apply(t_ones, b_ones);
    in_valid = 1'b1;
    wait_done(lat);
    in_valid = 1'b0;
    check("capture latency", 32'(lat), 32'd4);
    check("capture product", 32'(product), 32'(exp17[15:0]));
    check("capture ovf", 32'(ovf), 32'(exp17[16]));
    apply(t_zero, b_zero);
    release_out();

    // Reset sampled at the edge ending the second ACC cycle.
    accept("midrst", t_ones, b_ones);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst in_ready", 32'(in_ready), 32'd1);
    check("midrst product", 32'(product), 32'd0);
    check("midrst ovf", 32'(ovf), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("midrst stays idle", 32'({out_valid, in_ready}), 32'd1);

    // Normal operation after the mid-flight reset.
    exp17 = 17'd1 + BIAS_ADD;
    accept("post", vecs[1].t, vecs[1].b);
    wait_done(lat);
    check("post latency", 32'(lat), 32'd4);
    check("post product", 32'(product), 32'(exp17[15:0]));
    release_out();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
